seg_scan_scheduler: RTL and testbench
=====================================

// Module: seg_scan_scheduler
// PURPOSE
//  Time-multiplexed 7-segment refresh scheduler that owns the shared segment bus.
//  Cycles NUM_DIGITS hex digits onto segments/dp, one-hot digit_sel, with blanking between digits (anti-ghosting).
//  Double-buffered digit register with valid/ready load; buffer swap only at frame start (no tearing).
//  Sits between the project's value logic and uo_out[6:0] plus the digit-enable pins.
// PARAMETERS
//  NUM_DIGITS    4     digits scanned, legal 1..8
//  DWELL_CYCLES  1000  cycles each digit is driven, >=1 (multiple of 16 when DIMMING_EN)
//  BLANK_CYCLES  16    all-off cycles before each digit, >=1
// PORTS
//  clk        in   1              system clock, rising edge
//  rst        in   1              asynchronous reset, active-high
//  enable     in   1              1 = scan, 0 = dark/idle
//  wr_valid   in   1              load request
//  wr_ready   out  1              load accepted when wr_valid & wr_ready at clk edge
//  wr_data    in   4*NUM_DIGITS   digit i = wr_data[4i+3:4i]
//  wr_dp      in   NUM_DIGITS     decimal point per digit
//  brightness in   4              PWM duty (used only with DIMMING_EN)
//  segments   out  7              {g,f,e,d,c,b,a}, active-high
//  dp         out  1              decimal point, active-high
//  digit_sel  out  NUM_DIGITS     one-hot digit enable, active-high, bit i = digit i
//  frame_done out  1              1-cycle pulse at end of last digit's dwell
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, idx=0, cnt=0, shadow=active=0, pending=0;
//   segments=0, dp=0, digit_sel=0, frame_done=0; wr_ready=1.
//  wr_ready = !pending. Accepted write loads shadow (data+dp), sets pending.
//  FSM states IDLE, BLANK, DRIVE; cnt is the dwell/blank cycle counter:
//   IDLE : outputs dark; if pending, copy shadow->active, clear pending (one cycle).
//          enable=1 -> BLANK, idx=0, cnt=0.
//   BLANK: outputs dark; cnt==BLANK_CYCLES-1 -> DRIVE, cnt=0;
//          on this transition with idx==0 and pending: shadow->active, clear pending.
//   DRIVE: digit_sel=1<<idx, segments=hexdecode(active[idx]), dp=active_dp[idx];
//          cnt==DWELL_CYCLES-1 -> BLANK, cnt=0, idx=(idx==NUM_DIGITS-1)?0:idx+1;
//          frame_done=1 for that one cycle iff idx==NUM_DIGITS-1.
//  Outputs registered: digit_sel asserted exactly the DWELL_CYCLES cycles state==DRIVE.
//  Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
//  Latency: enable sampled high at edge k -> first digit_sel at edge k+BLANK_CYCLES.
//  enable=0 in any state -> IDLE at next edge, outputs dark, idx=0; shadow/pending kept.
//  Write during frame: displayed data unchanged until next idx-0 BLANK->DRIVE.
//  Swap and write same edge impossible (swap needs pending=1 -> wr_ready=0).
//  Hex decode 0..F: 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101
//   6=1111101 7=0000111 8=1111111 9=1101111 A=1110111 b=1111100 C=0111001
//   d=1011110 E=1111001 F=1110001.
//  Never more than one digit_sel bit high; no X on outputs after reset.
// CONFIGURATION
//  DIMMING_EN defined: in DRIVE, digit_sel/segments/dp gated on when cnt[3:0] < brightness;
//   brightness=0 -> dark, 15 -> 15/16 duty. FSM timing and frame_done unchanged.
//  DIMMING_EN undefined: brightness ignored, full duty in DRIVE.
// TESTING  (NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2)
//  1 rst=1 mid-run, no clk edge -> segments=0, digit_sel=0, dp=0, frame_done=0, wr_ready=1 at once.
//  2 write 16'h1234, enable=1 -> digit_sel 0001 seg 1100110 (8 cyc), 2 dark, 0010 seg 1001111,
//    ...; frame_done pulse every 40 cycles.
//  3 write 16'hABCD mid-digit-2 -> wr_ready=0, 1234 shown to frame end; next digit0 seg 1011110
//    ('d'), wr_ready=1 the cycle after swap.
//  4 enable=0 during digit 2 dwell -> next edge all dark; re-enable -> 2 blank cycles then digit 0.
//  5 after reset, enable=1 no write -> each digit seg 0111111 ('0'), dp=0.
//  6 DIMMING_EN, DWELL=16, brightness=4 -> digit_sel high 4 of 16 dwell cycles; brightness=0 -> never high.

Source files
------------

// File: rtl/seg_scan_scheduler.sv
// Multiplexed 7-segment refresh scheduler: blank/drive scan of NUM_DIGITS hex digits, double-buffered
// load with frame-aligned swap. Define DIMMING_EN to PWM-gate the drive phase with `brightness`.
module seg_scan_scheduler #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic [3:0]              brightness,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = ($clog2(CNT_MAX) < 4) ? 4 : $clog2(CNT_MAX);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      4'hF:    seg = 7'b1110001;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  state_t                  state_r, state_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [4*NUM_DIGITS-1:0] shadow_r, shadow_s, active_r, active_s;
  logic [NUM_DIGITS-1:0]   shadow_dp_r, shadow_dp_s, active_dp_r, active_dp_s;
  logic                    pending_r, pending_s;
  logic                    swap_s, lit_s;
  logic [NUM_DIGITS-1:0]   onehot_s;
  logic [3:0]              sel_nib_s;
  logic [6:0]              segments_r, segments_s;
  logic                    dp_r, dp_s, frame_done_r, frame_done_s;
  logic [NUM_DIGITS-1:0]   digit_sel_r, digit_sel_s;

  // Next state, buffer swap/load, and the output values that the next state will show
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    shadow_s    = shadow_r;
    shadow_dp_s = shadow_dp_r;
    active_s    = active_r;
    active_dp_s = active_dp_r;
    pending_s   = pending_r;
    swap_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        swap_s = pending_r;
        idx_s  = {IDX_W{1'b0}};
        cnt_s  = {CNT_W{1'b0}};
        if (enable) state_s = ST_BLANK;
        else        state_s = ST_IDLE;
      end
      ST_BLANK: begin
        if (!enable) begin
          state_s = ST_IDLE;
          idx_s   = {IDX_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == BLANK_LAST) begin
          state_s = ST_DRIVE;
          cnt_s   = {CNT_W{1'b0}};
          swap_s  = pending_r && (idx_r == {IDX_W{1'b0}});
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (!enable) begin
          state_s = ST_IDLE;
          idx_s   = {IDX_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == DWELL_LAST) begin
          state_s = ST_BLANK;
          cnt_s   = {CNT_W{1'b0}};
          idx_s   = (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = {IDX_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase

    // A swap needs pending=1, which holds wr_ready low, so swap and load never collide
    if (swap_s) begin
      active_s    = shadow_r;
      active_dp_s = shadow_dp_r;
      pending_s   = 1'b0;
    end else if (wr_valid && !pending_r) begin
      shadow_s    = wr_data;
      shadow_dp_s = wr_dp;
      pending_s   = 1'b1;
    end else begin
      pending_s = pending_r;
    end

    onehot_s  = ONE_HOT0 << idx_s;
    sel_nib_s = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_nib_s = sel_nib_s | (active_s[4*i +: 4] & {4{onehot_s[i]}});
    end

`ifdef DIMMING_EN
    lit_s = (state_s == ST_DRIVE) && (cnt_s[3:0] < brightness);
`else
    lit_s = (state_s == ST_DRIVE);
`endif
    digit_sel_s  = lit_s ? onehot_s : {NUM_DIGITS{1'b0}};
    segments_s   = lit_s ? hex_decode(sel_nib_s) : 7'b0000000;
    dp_s         = lit_s && (|(active_dp_s & onehot_s));
    frame_done_s = (state_s == ST_DRIVE) && (cnt_s == DWELL_LAST) && (idx_s == IDX_LAST);
  end

`ifndef DIMMING_EN
  logic unused_brightness_s;
  assign unused_brightness_s = ^brightness;
`endif

  // State, buffers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= {IDX_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      shadow_r     <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r  <= {NUM_DIGITS{1'b0}};
      active_r     <= {(4*NUM_DIGITS){1'b0}};
      active_dp_r  <= {NUM_DIGITS{1'b0}};
      pending_r    <= 1'b0;
      segments_r   <= 7'b0000000;
      dp_r         <= 1'b0;
      digit_sel_r  <= {NUM_DIGITS{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      cnt_r        <= cnt_s;
      shadow_r     <= shadow_s;
      shadow_dp_r  <= shadow_dp_s;
      active_r     <= active_s;
      active_dp_r  <= active_dp_s;
      pending_r    <= pending_s;
      segments_r   <= segments_s;
      dp_r         <= dp_s;
      digit_sel_r  <= digit_sel_s;
      frame_done_r <= frame_done_s;
    end
  end

  assign wr_ready   = !pending_r;
  assign segments   = segments_r;
  assign dp         = dp_r;
  assign digit_sel  = digit_sel_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler: frame-position reference model checked every cycle plus directed
// literal checks. With DIMMING_EN defined it uses a 16-cycle dwell and exercises brightness.
module tb_seg_scan_scheduler;

  localparam int N = 4;
`ifdef DIMMING_EN
  localparam int D = 16;
`else
  localparam int D = 8;
`endif
  localparam int B      = 2;
  localparam int SLOT   = B + D;
  localparam int PERIOD = N * SLOT;

  logic          clk, rst, enable, wr_valid, wr_ready, dp, frame_done;
  logic [4*N-1:0] wr_data;
  logic [N-1:0]   wr_dp, digit_sel;
  logic [3:0]     brightness;
  logic [6:0]     segments;

  int checks   = 0;
  int failures = 0;

  seg_scan_scheduler #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_dp(wr_dp), .brightness(brightness), .segments(segments),
    .dp(dp), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                               7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: running flag plus position within the frame, and the two data buffers
  logic           m_run, m_pending;
  int             m_pos;
  logic [4*N-1:0] m_active, m_shadow;
  logic [N-1:0]   m_adp, m_sdp;
  logic [3:0]     m_bright;

  always @(posedge clk or posedge rst) begin
    logic nrun, do_swap;
    int   npos;
    if (rst) begin
      m_run <= 1'b0; m_pos <= 0; m_pending <= 1'b0;
      m_active <= '0; m_shadow <= '0; m_adp <= '0; m_sdp <= '0; m_bright <= 4'd0;
    end else begin
      do_swap = 1'b0;
      if (!m_run) begin
        nrun = enable; npos = 0; do_swap = m_pending;
      end else if (!enable) begin
        nrun = 1'b0; npos = 0;
      end else begin
        nrun = 1'b1; npos = (m_pos + 1) % PERIOD; do_swap = m_pending && (npos == B);
      end
      if (do_swap) begin
        m_active <= m_shadow; m_adp <= m_sdp; m_pending <= 1'b0;
      end else if (wr_valid && !m_pending) begin
        m_shadow <= wr_data; m_sdp <= wr_dp; m_pending <= 1'b1;
      end
      m_run <= nrun; m_pos <= npos; m_bright <= brightness;
    end
  end

  // Compare DUT outputs against the model on every falling edge out of reset
  always @(negedge clk) begin
    int slot, off;
    logic drive, lit, e_fd, e_dp;
    logic [N-1:0] e_sel;
    logic [6:0] e_seg;
    logic [3:0] nib;
    if (!rst) begin
      slot  = m_pos / SLOT;
      off   = m_pos % SLOT;
      drive = m_run && (off >= B);
`ifdef DIMMING_EN
      lit   = drive && (((off - B) % 16) < int'(m_bright));
`else
      lit   = drive;
`endif
      e_fd  = drive && (slot == N - 1) && (off - B == D - 1);
      nib   = m_active[slot*4 +: 4];
      e_sel = lit ? N'(1 << slot) : '0;
      e_seg = lit ? hex_tab[nib] : 7'b0;
      e_dp  = lit && m_adp[slot];
      check("model_digit_sel", digit_sel, e_sel);
      check("model_segments", segments, e_seg);
      check("model_dp", dp, e_dp);
      check("model_frame_done", frame_done, e_fd);
      check("model_wr_ready", wr_ready, !m_pending);
    end
  end

  task automatic wait_sel(input logic [N-1:0] tgt);
    int n = 0;
    while (digit_sel !== tgt && n < 4 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    check("wait_digit_sel", digit_sel, tgt);
  endtask

  task automatic write(input logic [4*N-1:0] data, input logic [N-1:0] dps);
    wr_valid = 1'b1; wr_data = data; wr_dp = dps;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    int fd_cnt, lit_cnt;
    rst = 1'b1; enable = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_dp = '0; brightness = 4'd15;
    repeat (2) @(negedge clk);
    check("rst_digit_sel", digit_sel, 4'b0000);
    check("rst_wr_ready", wr_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Enable with no write: zeros displayed after B blank cycles
    enable = 1'b1;
    @(negedge clk); check("lat_blank0", digit_sel, 4'b0000);
    @(negedge clk); check("lat_blank1", digit_sel, 4'b0000);
    @(negedge clk);
    check("zero_sel", digit_sel, 4'b0001);
    check("zero_seg", segments, 7'b0111111);
    check("zero_dp", dp, 1'b0);
    repeat (PERIOD) @(negedge clk);

    // Load 1234 while idle, then scan
    enable = 1'b0;
    @(negedge clk);
    write(16'h1234, 4'b0100);
    check("load_ready_low", wr_ready, 1'b0);
    enable = 1'b1;
    @(negedge clk); check("idle_swap_ready", wr_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("d0_sel", digit_sel, 4'b0001);
    check("d0_seg", segments, 7'b1100110);
    repeat (SLOT) @(negedge clk);
    check("d1_sel", digit_sel, 4'b0010);
    check("d1_seg", segments, 7'b1001111);
    fd_cnt = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    check("frame_done_count", fd_cnt, 2);

    // Write ABCD during digit 2: old data until the next frame start
    wait_sel(4'b0100);
    write(16'hABCD, 4'b0001);
    check("mid_write_ready_low", wr_ready, 1'b0);
    check("mid_write_old_seg", segments, 7'b1011011);
    wait_sel(4'b0001);
    check("swap_seg_d", segments, 7'b1011110);
    check("swap_dp", dp, 1'b1);
    check("swap_ready", wr_ready, 1'b1);

    // Disable during digit 2, then re-enable
    wait_sel(4'b0100);
    enable = 1'b0;
    @(negedge clk);
    check("dis_sel", digit_sel, 4'b0000);
    check("dis_seg", segments, 7'b0000000);
    enable = 1'b1;
    @(negedge clk); check("reen_blank0", digit_sel, 4'b0000);
    @(negedge clk); check("reen_blank1", digit_sel, 4'b0000);
    @(negedge clk);
    check("reen_sel", digit_sel, 4'b0001);
    check("reen_seg", segments, 7'b1011110);

    // Asynchronous reset between edges while driving with a pending write
    repeat (4) @(negedge clk);
    write(16'h5555, 4'b1111);
    check("pre_rst_ready", wr_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_seg", segments, 7'b0000000);
    check("arst_sel", digit_sel, 4'b0000);
    check("arst_dp", dp, 1'b0);
    check("arst_fd", frame_done, 1'b0);
    check("arst_ready", wr_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef DIMMING_EN
    brightness = 4'd4;
    wait_sel(4'b0001);
    repeat (PERIOD) @(negedge clk);
    lit_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (digit_sel != '0) lit_cnt++;
    end
    check("dim4_lit_cycles", lit_cnt, 4 * N);
    brightness = 4'd0;
    repeat (2) @(negedge clk);
    lit_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (digit_sel != '0) lit_cnt++;
    end
    check("dim0_lit_cycles", lit_cnt, 0);
`else
    lit_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (digit_sel != '0) lit_cnt++;
    end
    check("full_duty_lit_cycles", lit_cnt, D * N);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
